// File: rtl/mem_perf_pkg.sv
// -----------------------------------------------------------------------------
// mem_perf_pkg
// Shared definitions for the memory-bus performance monitor: the counter
// index encoding used by the readback port and the number of counters per
// channel.
// -----------------------------------------------------------------------------
package mem_perf_pkg;

  localparam int CNT_IDX_W = 2;
  localparam int NUM_CNT   = 4;

  // Readback index of each per-channel counter. Stalls is deliberately last so
  // that a build without stall counters is simply "the first three".
  typedef enum logic [CNT_IDX_W-1:0] {
    CNT_READS  = 2'd0,
    CNT_WRITES = 2'd1,
    CNT_MISSES = 2'd2,
    CNT_STALLS = 2'd3
  } cnt_idx_e;

endpackage

// File: rtl/perf_sat_counter.sv
// -----------------------------------------------------------------------------
// perf_sat_counter
// Saturating up-counter. A synchronous clear has priority over an increment;
// at all-ones the count holds instead of wrapping.
//
// Ports
//   clk    in  1   rising-edge clock
//   reset  in  1   asynchronous, active-high reset
//   clr    in  1   synchronous clear (wins over inc)
//   inc    in  1   increment request
//   q      out W   current count
// -----------------------------------------------------------------------------
module perf_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // NOTE: cnt_d gets a default before any branch, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state is written with non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/mem_perf_monitor.sv
// -----------------------------------------------------------------------------
// mem_perf_monitor
// Passive NUM_CH-channel memory-bus performance monitor. Per channel it counts
// completed reads, completed writes, cache misses (rising edges of the miss
// level) and, optionally, stall cycles. A snapshot pulse copies the live
// counters into holding registers that the host reads through a registered
// select port. The first out-of-range transfer is captured in sticky error
// registers that only reset clears.
//
// Build option: define PERF_STALL_CNT_EN to build the stall counters and their
// snapshots; without it no stall registers exist and index 3 reads as 0.
//
// Ports
//   clk        in   1              rising-edge clock
//   reset      in   1              asynchronous, active-high reset
//   mon_valid  in   NUM_CH         per-channel request valid
//   mon_ready  in   NUM_CH         per-channel ready
//   mon_write  in   NUM_CH         1 = transaction is a write
//   mon_miss   in   NUM_CH         cache miss level; rising edge = one miss
//   mon_addr   in   NUM_CH*ADDR_W  channel i address at [i*ADDR_W +: ADDR_W]
//   cnt_en     in   1              counting enable
//   cnt_clear  in   1              pulse: zero all live counters
//   snap       in   1              pulse: copy live counters to snapshots
//   rd_en      in   1              readback request
//   rd_ch      in   CH_W           readback channel select
//   rd_idx     in   2              readback counter select (cnt_idx_e)
//   rd_valid   out  1              rd_data valid, one cycle after rd_en
//   rd_data    out  CNT_W          selected snapshot value
//   err_oob    out  1              sticky out-of-range flag
//   err_ch     out  CH_W           channel of the first out-of-range transfer
//   err_addr   out  ADDR_W         address of the first out-of-range transfer
// -----------------------------------------------------------------------------
module mem_perf_monitor
  import mem_perf_pkg::*;
#(
  parameter int                NUM_CH    = 2,
  parameter int                ADDR_W    = 32,
  parameter int                CNT_W     = 32,
  parameter logic [ADDR_W-1:0] MEM_SIZE  = 32'h0010_0000,
  parameter logic [ADDR_W-1:0] MMIO_ADDR = 32'h1000_0000,
  localparam int               CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        mon_valid,
  input  logic [NUM_CH-1:0]        mon_ready,
  input  logic [NUM_CH-1:0]        mon_write,
  input  logic [NUM_CH-1:0]        mon_miss,
  input  logic [NUM_CH*ADDR_W-1:0] mon_addr,
  input  logic                     cnt_en,
  input  logic                     cnt_clear,
  input  logic                     snap,
  input  logic                     rd_en,
  input  logic [CH_W-1:0]          rd_ch,
  input  logic [CNT_IDX_W-1:0]     rd_idx,
  output logic                     rd_valid,
  output logic [CNT_W-1:0]         rd_data,
  output logic                     err_oob,
  output logic [CH_W-1:0]          err_ch,
  output logic [ADDR_W-1:0]        err_addr
);

  // Counters actually built per channel. Stalls is the last index, so without
  // the stall option the built set is indices [0, CNT_STALLS).
`ifdef PERF_STALL_CNT_EN
  localparam int NUM_BUILT = NUM_CNT;
`else
  localparam int NUM_BUILT = int'(CNT_STALLS);
`endif

  logic [NUM_CH-1:0]    miss_q;
  logic [NUM_CH-1:0]    xfer;
  logic [NUM_BUILT-1:0] ev     [NUM_CH];
  logic [CNT_W-1:0]     live   [NUM_CH][NUM_BUILT];
  logic [CNT_W-1:0]     snap_q [NUM_CH][NUM_BUILT];

  logic                 rd_valid_q;
  logic [CNT_W-1:0]     rd_data_q;
  logic [CNT_W-1:0]     rd_data_d;

  logic                 oob_hit;
  logic [CH_W-1:0]      oob_ch_d;
  logic [ADDR_W-1:0]    oob_addr_d;
  logic                 err_oob_q;
  logic [CH_W-1:0]      err_ch_q;
  logic [ADDR_W-1:0]    err_addr_q;

  assign xfer = mon_valid & mon_ready;

  // Per-channel event vector, one bit per built counter.
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      ev[ch]             = '0;
      ev[ch][CNT_READS]  = xfer[ch] & ~mon_write[ch];
      ev[ch][CNT_WRITES] = xfer[ch] &  mon_write[ch];
      ev[ch][CNT_MISSES] = mon_miss[ch] & ~miss_q[ch];
`ifdef PERF_STALL_CNT_EN
      ev[ch][CNT_STALLS] = mon_valid[ch] & ~mon_ready[ch];
`endif
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    for (genvar k = 0; k < NUM_BUILT; k++) begin : g_cnt
      perf_sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clear),
        .inc   (cnt_en & ev[ch][k]),
        .q     (live[ch][k])
      );
    end
  end

  // The miss-edge register tracks the level every cycle regardless of cnt_en,
  // so a miss already high when counting (re)starts is not counted.
  // NOTE: the snapshot array is reset element by element because a readback
  // straight after reset must return 0, not power-up garbage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      miss_q <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        for (int k = 0; k < NUM_BUILT; k++) begin
          snap_q[ch][k] <= '0;
        end
      end
    end else begin
      miss_q <= mon_miss;
      // live[] still holds pre-edge values here, so a snapshot taken together
      // with a clear or an increment captures the value before either.
      if (snap) begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
          for (int k = 0; k < NUM_BUILT; k++) begin
            snap_q[ch][k] <= live[ch][k];
          end
        end
      end
    end
  end

  // Readback select; an unmatched channel or an unbuilt counter yields 0.
  always_comb begin
    rd_data_d = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      for (int k = 0; k < NUM_BUILT; k++) begin
        if ((rd_ch == CH_W'(ch)) && (rd_idx == CNT_IDX_W'(k))) begin
          rd_data_d = snap_q[ch][k];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_data_q <= rd_data_d;
      end
    end
  end

  // Out-of-range detection. Scanning from the highest channel down lets the
  // lowest offending channel overwrite the others.
  always_comb begin
    oob_hit    = 1'b0;
    oob_ch_d   = '0;
    oob_addr_d = '0;
    for (int ch = NUM_CH - 1; ch >= 0; ch--) begin
      if (xfer[ch] &&
          (mon_addr[ch*ADDR_W +: ADDR_W] >= MEM_SIZE) &&
          (mon_addr[ch*ADDR_W +: ADDR_W] != MMIO_ADDR)) begin
        oob_hit    = 1'b1;
        oob_ch_d   = CH_W'(ch);
        oob_addr_d = mon_addr[ch*ADDR_W +: ADDR_W];
      end
    end
  end

  // Only the first offence is recorded; cnt_clear deliberately leaves it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_oob_q  <= 1'b0;
      err_ch_q   <= '0;
      err_addr_q <= '0;
    end else if (oob_hit && !err_oob_q) begin
      err_oob_q  <= 1'b1;
      err_ch_q   <= oob_ch_d;
      err_addr_q <= oob_addr_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign err_oob  = err_oob_q;
  assign err_ch   = err_ch_q;
  assign err_addr = err_addr_q;

endmodule

// File: tb/tb_mem_perf_monitor.sv
// -----------------------------------------------------------------------------
// tb_mem_perf_monitor
// Drives two monitors from the same stimulus: a 32-bit-counter instance and a
// 4-bit-counter instance that exercises saturation. A reference model of the
// counting rules predicts every readback; expected values go into a queue and
// a negedge monitor compares them whenever rd_valid is seen, and also compares
// the error capture outputs every cycle.
// -----------------------------------------------------------------------------
module tb_mem_perf_monitor;
  import mem_perf_pkg::*;

  localparam int          NUM_CH   = 2;
  localparam int          ADDR_W   = 32;
  localparam longint      MAX32    = 64'h0000_0000_FFFF_FFFF;
  localparam longint      MAX4     = 15;
  localparam logic [31:0] MEM_SIZE = 32'h0010_0000;
  localparam logic [31:0] MMIO     = 32'h1000_0000;
`ifdef PERF_STALL_CNT_EN
  localparam bit          STALL_ON = 1'b1;
`else
  localparam bit          STALL_ON = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic [NUM_CH-1:0]        mon_valid = '0, mon_ready = '0, mon_write = '0, mon_miss = '0;
  logic [NUM_CH*ADDR_W-1:0] mon_addr = '0;
  logic                     cnt_en = 1'b0, cnt_clear = 1'b0, snap = 1'b0, rd_en = 1'b0;
  logic [0:0]               rd_ch = '0;
  logic [1:0]               rd_idx = '0;

  logic        rd_valid, err_oob, rd_valid4, err_oob4;
  logic [31:0] rd_data, err_addr, err_addr4;
  logic [3:0]  rd_data4;
  logic [0:0]  err_ch, err_ch4;

  mem_perf_monitor dut (
    .clk(clk), .reset(reset), .mon_valid(mon_valid), .mon_ready(mon_ready),
    .mon_write(mon_write), .mon_miss(mon_miss), .mon_addr(mon_addr),
    .cnt_en(cnt_en), .cnt_clear(cnt_clear), .snap(snap), .rd_en(rd_en),
    .rd_ch(rd_ch), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_data(rd_data),
    .err_oob(err_oob), .err_ch(err_ch), .err_addr(err_addr)
  );

  mem_perf_monitor #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .mon_valid(mon_valid), .mon_ready(mon_ready),
    .mon_write(mon_write), .mon_miss(mon_miss), .mon_addr(mon_addr),
    .cnt_en(cnt_en), .cnt_clear(cnt_clear), .snap(snap), .rd_en(rd_en),
    .rd_ch(rd_ch), .rd_idx(rd_idx), .rd_valid(rd_valid4), .rd_data(rd_data4),
    .err_oob(err_oob4), .err_ch(err_ch4), .err_addr(err_addr4)
  );

  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------- reference model ----------------
  // Index 0 models the 32-bit instance, index 1 the 4-bit instance.
  longint      live  [2][NUM_CH][4];
  longint      snapm [2][NUM_CH][4];
  bit          miss_prev [NUM_CH];
  bit          m_err;
  int          m_err_ch;
  logic [31:0] m_err_addr;

  typedef struct {
    longint e32;
    longint e4;
    string  name;
  } exp_t;
  exp_t sb_q[$];

  // A directed read can supply literal expectations instead of the model's.
  bit     dir_valid = 1'b0;
  longint dir32, dir4;
  string  dir_name;

  function automatic longint max_of(int w);
    return (w == 0) ? MAX32 : MAX4;
  endfunction

  function automatic logic [31:0] addr_of(int ch);
    return mon_addr[ch*ADDR_W +: ADDR_W];
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 2; w++)
      for (int c = 0; c < NUM_CH; c++)
        for (int k = 0; k < 4; k++) begin
          live[w][c][k]  = 0;
          snapm[w][c][k] = 0;
        end
    for (int c = 0; c < NUM_CH; c++) miss_prev[c] = 1'b0;
    m_err      = 1'b0;
    m_err_ch   = 0;
    m_err_addr = '0;
  endtask

  // Advance the model across one rising edge using the inputs held there.
  task automatic model_step();
    exp_t e;
    bit   evt [4];
    if (reset) begin
      model_reset();
      return;
    end
    if (rd_en) begin
      if (dir_valid) begin
        e.e32 = dir32; e.e4 = dir4; e.name = dir_name;
      end else begin
        e.e32  = snapm[0][rd_ch][rd_idx];
        e.e4   = snapm[1][rd_ch][rd_idx];
        e.name = $sformatf("rd_ch%0d_idx%0d", rd_ch, rd_idx);
      end
      sb_q.push_back(e);
    end
    if (snap) snapm = live;
    for (int c = 0; c < NUM_CH; c++) begin
      evt[0] = mon_valid[c] && mon_ready[c] && !mon_write[c];
      evt[1] = mon_valid[c] && mon_ready[c] &&  mon_write[c];
      evt[2] = mon_miss[c] && !miss_prev[c];
      evt[3] = STALL_ON && mon_valid[c] && !mon_ready[c];
      for (int w = 0; w < 2; w++)
        for (int k = 0; k < 4; k++) begin
          if (cnt_clear)          live[w][c][k] = 0;
          else if (cnt_en && evt[k] && live[w][c][k] < max_of(w))
                                  live[w][c][k] = live[w][c][k] + 1;
        end
      miss_prev[c] = mon_miss[c];
    end
    if (!m_err) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!m_err && mon_valid[c] && mon_ready[c] &&
            addr_of(c) >= MEM_SIZE && addr_of(c) != MMIO) begin
          m_err = 1'b1; m_err_ch = c; m_err_addr = addr_of(c);
        end
      end
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      check("err_oob",    err_oob,   m_err);
      check("err_ch",     err_ch,    m_err ? m_err_ch : 0);
      check("err_addr",   err_addr,  m_err_addr);
      check("err_oob_w4", err_oob4,  m_err);
      check("err_addr_w4", err_addr4, m_err_addr);
      if (rd_valid || rd_valid4) begin
        if (sb_q.size() == 0) begin
          check("rd_valid_unexpected", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check({e.name, "_valid"},    rd_valid,  1);
          check({e.name, "_valid_w4"}, rd_valid4, 1);
          check(e.name,                rd_data,   e.e32);
          check({e.name, "_w4"},       rd_data4,  e.e4);
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    snap = 0; cnt_clear = 0; rd_en = 0; dir_valid = 0;
    mon_valid = '0; mon_ready = '0; mon_write = '0;
  endtask

  task automatic xfer(input int ch, input bit wr, input logic [31:0] addr);
    mon_valid[ch] = 1'b1;
    mon_ready[ch] = 1'b1;
    mon_write[ch] = wr;
    mon_addr[ch*ADDR_W +: ADDR_W] = addr;
  endtask

  task automatic read_chk(input int ch, input int idx, input longint e32,
                          input longint e4, input string name);
    rd_en = 1; rd_ch = 1'(ch); rd_idx = 2'(idx);
    dir_valid = 1; dir32 = e32; dir4 = e4; dir_name = name;
    tick();
  endtask

  task automatic apply_reset();
    reset = 1;
    #1;
    model_reset();
    sb_q.delete();
    check("rst_rd_valid", rd_valid, 0);  check("rst_rd_data", rd_data, 0);
    check("rst_err_oob", err_oob, 0);    check("rst_err_ch", err_ch, 0);
    check("rst_err_addr", err_addr, 0);  check("rst_rd_valid_w4", rd_valid4, 0);
    check("rst_rd_data_w4", rd_data4, 0); check("rst_err_oob_w4", err_oob4, 0);
    repeat (2) tick();
    reset = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    apply_reset();
    cnt_en = 1;
    read_chk(0, 0, 0, 0, "reset_snap_reads");

    // 1: five reads on ch0
    cnt_clear = 1; tick();
    for (int i = 0; i < 5; i++) begin xfer(0, 0, 32'h100 + 32'(4*i)); tick(); end
    snap = 1; tick();
    read_chk(0, 0, 5, 5, "t1_reads");
    read_chk(0, 1, 0, 0, "t1_writes");

    // 2: ch1 write stalled for three cycles
    for (int i = 0; i < 4; i++) begin
      mon_valid[1] = 1; mon_ready[1] = (i == 3); mon_write[1] = 1;
      mon_addr[ADDR_W +: ADDR_W] = 32'h200;
      tick();
    end
    snap = 1; tick();
    read_chk(1, 3, STALL_ON ? 3 : 0, STALL_ON ? 3 : 0, "t2_stalls");
    read_chk(1, 1, 1, 1, "t2_writes");

    // 3: miss edges, and a miss held high across a clear
    mon_miss[0] = 1; repeat (3) tick();
    mon_miss[0] = 0; tick();
    mon_miss[0] = 1; repeat (2) tick();
    snap = 1; tick();
    read_chk(0, 2, 2, 2, "t3_misses");
    cnt_clear = 1; tick(); tick();
    snap = 1; tick();
    read_chk(0, 2, 0, 0, "t3_miss_no_recount");
    mon_miss[0] = 0; tick();

    // 4: saturation and clear/snap priority
    cnt_clear = 1; tick();
    for (int i = 0; i < 20; i++) begin xfer(0, 0, 32'h400); tick(); end
    snap = 1; tick();
    read_chk(0, 0, 20, 15, "t4_saturate");
    for (int i = 0; i < 3; i++) begin xfer(0, 0, 32'h400); tick(); end
    snap = 1; tick();
    read_chk(0, 0, 23, 15, "t4_no_wrap");
    cnt_clear = 1; xfer(0, 0, 32'h400); tick();
    snap = 1; tick();
    read_chk(0, 0, 0, 0, "t4_clear_beats_inc");
    for (int i = 0; i < 2; i++) begin xfer(0, 0, 32'h400); tick(); end
    snap = 1; cnt_clear = 1; tick();
    read_chk(0, 0, 2, 2, "t4_snap_pre_clear");
    snap = 1; xfer(0, 0, 32'h400); tick();
    read_chk(0, 0, 0, 0, "t4_snap_pre_inc");
    snap = 1; tick();
    read_chk(0, 0, 1, 1, "t4_after_inc");

    // 5: simultaneous out-of-range transfers; lowest channel wins, then sticky
    check("t5_err_before", err_oob, 0);
    xfer(1, 0, 32'h0010_0000); xfer(0, 1, 32'h0020_0000); tick();
    check("t5_err_oob", err_oob, 1);
    check("t5_err_ch", err_ch, 0);
    check("t5_err_addr", err_addr, 32'h0020_0000);
    xfer(0, 0, 32'h1000_0000); xfer(1, 0, 32'h0030_0000); cnt_clear = 1; tick();
    check("t5_sticky_ch", err_ch, 0);
    check("t5_sticky_addr", err_addr, 32'h0020_0000);

    // 6: reset while ch0 is stalled and readback data is nonzero
    for (int i = 0; i < 3; i++) begin xfer(0, 0, 32'h80); tick(); end
    snap = 1; tick();
    read_chk(0, 0, 3, 3, "t6_pre_reset");
    @(negedge clk); #1;
    mon_valid[0] = 1; mon_ready[0] = 0;
    apply_reset();
    for (int i = 0; i < 3; i++) begin mon_valid[0] = 1; mon_ready[0] = 0; tick(); end
    snap = 1; tick();
    read_chk(0, 3, STALL_ON ? 3 : 0, STALL_ON ? 3 : 0, "t6_stalls_after_reset");
    read_chk(0, 0, 0, 0, "t6_reads_after_reset");

    // Random traffic checked against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) apply_reset();
      mon_valid = NUM_CH'($urandom); mon_ready = NUM_CH'($urandom);
      mon_write = NUM_CH'($urandom);
      for (int c = 0; c < NUM_CH; c++) begin
        int sel;
        if ($urandom_range(0, 2) == 0) mon_miss[c] = ~mon_miss[c];
        sel = $urandom_range(0, 39);
        if (sel == 0)      mon_addr[c*ADDR_W +: ADDR_W] = MMIO;
        else if (sel == 1) mon_addr[c*ADDR_W +: ADDR_W] = MEM_SIZE + $urandom_range(0, 255);
        else if (sel == 2) mon_addr[c*ADDR_W +: ADDR_W] = MEM_SIZE - 1;
        else               mon_addr[c*ADDR_W +: ADDR_W] = $urandom_range(0, 32'h000F_FFFF);
      end
      cnt_en    = ($urandom_range(0, 9) != 0);
      cnt_clear = ($urandom_range(0, 99) < 2);
      snap      = ($urandom_range(0, 9) == 0);
      rd_en     = ($urandom_range(0, 2) == 0);
      rd_ch     = 1'($urandom);
      rd_idx    = 2'($urandom);
      tick();
    end

    repeat (3) tick();
    check("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
